// File: rtl/led_seq_player.sv
// ---------------------------------------------------------------------------
// led_seq_player
//
// Multi-channel LED pattern sequencer. Plays up to STEPS steps of a CH-bit
// pattern, holding each step on the LED pins for a programmable number of
// clock cycles. Supports looping and one-shot playback, start/stop control,
// a valid/ready configuration port, and double-buffered reload of the
// configuration at pattern wrap.
//
// Ports
//   sys_clk      in   1         system clock, rising edge
//   rst          in   1         asynchronous active-high reset
//   cfg_valid    in   1         configuration word valid
//   cfg_ready    out  1         configuration accepted when cfg_valid & cfg_ready
//   cfg_pattern  in   CH*STEPS  step k drives bits [k*CH +: CH]
//   cfg_last     in   SW        index of last played step (clamped to STEPS-1)
//   cfg_time     in   TW        cycles per step (0 behaves as 1)
//   cfg_oneshot  in   1         1 = play once then stop, 0 = loop
//   start        in   1         level, starts playback while idle
//   stop         in   1         aborts playback
//   led          out  CH        current step pattern (registered)
//   busy         out  1         high while playing
//   done         out  1         single-cycle pulse when a one-shot completes
//   step_idx     out  SW        index of the step currently on led
// ---------------------------------------------------------------------------
module led_seq_player #(
    parameter int  CH    = 4,
    parameter int  STEPS = 8,
    parameter int  TW    = 32,
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1,
    localparam int PW    = CH * STEPS
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [PW-1:0] cfg_pattern,
    input  logic [SW-1:0] cfg_last,
    input  logic [TW-1:0] cfg_time,
    input  logic          cfg_oneshot,
    input  logic          start,
    input  logic          stop,
    output logic [CH-1:0] led,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] step_idx
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Select the CH-bit slice of a pattern belonging to step idx.
    function automatic logic [CH-1:0] pat_step(input logic [PW-1:0] pat,
                                               input logic [SW-1:0] idx);
        logic [CH-1:0] res;
        res = {CH{1'b0}};
        for (int k = 0; k < STEPS; k++) begin
            res = (idx == SW'(k)) ? pat[k*CH +: CH] : res;
        end
        return res;
    endfunction

    // Clamp a requested last-step index into the implemented step range.
    // The comparison is done at 32 bits so it stays meaningful when STEPS
    // is a power of two and the clamp can never trigger.
    function automatic logic [SW-1:0] clamp_last(input logic [SW-1:0] v);
        logic [31:0] v_w;
        v_w = 32'(v);
        return (v_w > 32'(STEPS - 1)) ? SW'(STEPS - 1) : v;
    endfunction

    logic [0:0]    state_q,        state_d;
    logic [SW-1:0] step_q,         step_d;
    logic [TW-1:0] tcnt_q,         tcnt_d;
    logic [CH-1:0] led_q,          led_d;
    logic          busy_q,         busy_d;
    logic          done_q,         done_d;
    logic          pending_q,      pending_d;

    logic [PW-1:0] act_pattern_q,  act_pattern_d;
    logic [SW-1:0] act_last_q,     act_last_d;
    logic [TW-1:0] act_time_q,     act_time_d;
    logic          act_oneshot_q,  act_oneshot_d;

    logic [PW-1:0] shd_pattern_q,  shd_pattern_d;
    logic [SW-1:0] shd_last_q,     shd_last_d;
    logic [TW-1:0] shd_time_q,     shd_time_d;
    logic          shd_oneshot_q,  shd_oneshot_d;

    logic          cfg_accept_s;
    logic [SW-1:0] cfg_last_clamped_s;
    logic [TW-1:0] t_last_s;
    logic          step_end_s;
    logic          leave_s;

    // Handshake and per-step timing helpers.
    always_comb begin
        cfg_ready          = ~pending_q;
        cfg_accept_s       = cfg_valid & ~pending_q;
        cfg_last_clamped_s = clamp_last(cfg_last);
        // A programmed time of 0 holds each step for one cycle, like 1.
        t_last_s           = (act_time_q == TW'(0)) ? TW'(0) : (act_time_q - TW'(1));
        step_end_s         = (tcnt_q == t_last_s);
    end

    // Next-state logic for the player FSM, the active config and the shadow config.
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        tcnt_d        = tcnt_q;
        led_d         = led_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        pending_d     = pending_q;
        act_pattern_d = act_pattern_q;
        act_last_d    = act_last_q;
        act_time_d    = act_time_q;
        act_oneshot_d = act_oneshot_q;
        shd_pattern_d = shd_pattern_q;
        shd_last_d    = shd_last_q;
        shd_time_d    = shd_time_q;
        shd_oneshot_d = shd_oneshot_q;
        leave_s       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_accept_s) begin
                    act_pattern_d = cfg_pattern;
                    act_last_d    = cfg_last_clamped_s;
                    act_time_d    = cfg_time;
                    act_oneshot_d = cfg_oneshot;
                end else begin
                    act_pattern_d = act_pattern_q;
                end
                if (start && !stop) begin
                    // A config accepted in this same cycle is the one played.
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    step_d  = {SW{1'b0}};
                    tcnt_d  = {TW{1'b0}};
                    led_d   = pat_step(cfg_accept_s ? cfg_pattern : act_pattern_q, {SW{1'b0}});
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    step_d  = {SW{1'b0}};
                    tcnt_d  = {TW{1'b0}};
                    led_d   = {CH{1'b0}};
                end
            end

            ST_RUN: begin
                if (stop) begin
                    leave_s = 1'b1;
                end else if (step_end_s) begin
                    tcnt_d = {TW{1'b0}};
                    if (step_q == act_last_q) begin
                        if (act_oneshot_q) begin
                            leave_s = 1'b1;
                            done_d  = 1'b1;
                        end else if (pending_q) begin
                            // Wrap onto the reloaded config; led shows its step 0 at once.
                            step_d        = {SW{1'b0}};
                            act_pattern_d = shd_pattern_q;
                            act_last_d    = shd_last_q;
                            act_time_d    = shd_time_q;
                            act_oneshot_d = shd_oneshot_q;
                            pending_d     = 1'b0;
                            led_d         = pat_step(shd_pattern_q, {SW{1'b0}});
                        end else begin
                            step_d = {SW{1'b0}};
                            led_d  = pat_step(act_pattern_q, {SW{1'b0}});
                        end
                    end else begin
                        step_d = step_q + SW'(1);
                        led_d  = pat_step(act_pattern_q, step_q + SW'(1));
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end

                if (leave_s) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    step_d  = {SW{1'b0}};
                    tcnt_d  = {TW{1'b0}};
                    led_d   = {CH{1'b0}};
                    // Leaving RUN: the newest config becomes active so that idle
                    // never holds a stale shadow with cfg_ready low. A word accepted
                    // on this very edge is newer than any pending one.
                    if (cfg_accept_s) begin
                        act_pattern_d = cfg_pattern;
                        act_last_d    = cfg_last_clamped_s;
                        act_time_d    = cfg_time;
                        act_oneshot_d = cfg_oneshot;
                    end else if (pending_q) begin
                        act_pattern_d = shd_pattern_q;
                        act_last_d    = shd_last_q;
                        act_time_d    = shd_time_q;
                        act_oneshot_d = shd_oneshot_q;
                    end else begin
                        act_pattern_d = act_pattern_q;
                    end
                    pending_d = 1'b0;
                end else if (cfg_accept_s) begin
                    // Only possible while not pending, so it never collides with
                    // a reload on this edge; it takes effect at the next wrap.
                    shd_pattern_d = cfg_pattern;
                    shd_last_d    = cfg_last_clamped_s;
                    shd_time_d    = cfg_time;
                    shd_oneshot_d = cfg_oneshot;
                    pending_d     = 1'b1;
                end else begin
                    shd_pattern_d = shd_pattern_q;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                step_d    = {SW{1'b0}};
                tcnt_d    = {TW{1'b0}};
                led_d     = {CH{1'b0}};
                pending_d = 1'b0;
            end
        endcase
    end

    // Registers with asynchronous reset to idle and the default active config.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            step_q        <= {SW{1'b0}};
            tcnt_q        <= {TW{1'b0}};
            led_q         <= {CH{1'b0}};
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pending_q     <= 1'b0;
            act_pattern_q <= {PW{1'b0}};
            act_last_q    <= SW'(STEPS - 1);
            act_time_q    <= TW'(1);
            act_oneshot_q <= 1'b0;
            shd_pattern_q <= {PW{1'b0}};
            shd_last_q    <= SW'(STEPS - 1);
            shd_time_q    <= TW'(1);
            shd_oneshot_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            tcnt_q        <= tcnt_d;
            led_q         <= led_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pending_q     <= pending_d;
            act_pattern_q <= act_pattern_d;
            act_last_q    <= act_last_d;
            act_time_q    <= act_time_d;
            act_oneshot_q <= act_oneshot_d;
            shd_pattern_q <= shd_pattern_d;
            shd_last_q    <= shd_last_d;
            shd_time_q    <= shd_time_d;
            shd_oneshot_q <= shd_oneshot_d;
        end
    end

    assign led      = led_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_idx = step_q;

endmodule

// File: tb/tb_led_seq_player.sv
// Testbench for led_seq_player: directed scenarios plus randomized traffic,
// all checked against a step/countdown reference model of the player.
// STEPS=6 is used so that out-of-range last-step indices are representable.
module tb_led_seq_player;

    localparam int CH    = 4;
    localparam int STEPS = 6;
    localparam int TW    = 16;
    localparam int SW    = 3;
    localparam int PW    = CH * STEPS;

    logic          sys_clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [PW-1:0] cfg_pattern = '0;
    logic [SW-1:0] cfg_last = '0;
    logic [TW-1:0] cfg_time = '0;
    logic          cfg_oneshot = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [CH-1:0] led;
    logic          busy;
    logic          done;
    logic [SW-1:0] step_idx;

    led_seq_player #(.CH(CH), .STEPS(STEPS), .TW(TW)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_last(cfg_last), .cfg_time(cfg_time),
        .cfg_oneshot(cfg_oneshot), .start(start), .stop(stop),
        .led(led), .busy(busy), .done(done), .step_idx(step_idx)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [PW-1:0] pat;
        int            last;
        int            t;
        bit            os;
    } cfg_t;

    cfg_t          m_act, m_shd;
    bit            m_run, m_pending, m_done;
    int            m_step, m_left;   // m_left = cycles the current step still shows
    logic [CH-1:0] m_led;

    function automatic logic [CH-1:0] slice(input logic [PW-1:0] p, input int k);
        return p[k*CH +: CH];
    endfunction

    task automatic model_reset();
        m_act.pat = '0; m_act.last = STEPS - 1; m_act.t = 1; m_act.os = 1'b0;
        m_shd = m_act;
        m_run = 1'b0; m_pending = 1'b0; m_done = 1'b0;
        m_step = 0; m_left = 0; m_led = '0;
    endtask

    task automatic model_step();
        cfg_t inc;
        bit   accept, leave;
        if (rst) begin
            model_reset();
            return;
        end
        inc.pat  = cfg_pattern;
        inc.last = (int'(cfg_last) > STEPS - 1) ? STEPS - 1 : int'(cfg_last);
        inc.t    = (cfg_time == 0) ? 1 : int'(cfg_time);
        inc.os   = cfg_oneshot;
        accept   = cfg_valid && !m_pending;
        m_done   = 1'b0;
        leave    = 1'b0;
        if (!m_run) begin
            if (accept) m_act = inc;
            if (start && !stop) begin
                m_run = 1'b1; m_step = 0; m_left = m_act.t; m_led = slice(m_act.pat, 0);
            end
        end else begin
            if (stop) leave = 1'b1;
            else begin
                m_left--;
                if (m_left == 0) begin
                    if (m_step == m_act.last) begin
                        if (m_act.os) begin
                            leave = 1'b1; m_done = 1'b1;
                        end else begin
                            if (m_pending) begin m_act = m_shd; m_pending = 1'b0; end
                            m_step = 0; m_left = m_act.t; m_led = slice(m_act.pat, 0);
                        end
                    end else begin
                        m_step++; m_left = m_act.t; m_led = slice(m_act.pat, m_step);
                    end
                end
            end
            if (leave) begin
                m_run = 1'b0; m_step = 0; m_led = '0;
                if (accept) m_act = inc;
                else if (m_pending) m_act = m_shd;
                m_pending = 1'b0;
            end else if (accept) begin
                m_shd = inc; m_pending = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("led",       32'(led),       32'(m_led));
        check_eq("busy",      32'(busy),      32'(m_run));
        check_eq("done",      32'(done),      32'(m_done));
        check_eq("step_idx",  32'(step_idx),  32'(m_step));
        check_eq("cfg_ready", 32'(cfg_ready), 32'(!m_pending));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        compare_all();
    endtask

    task automatic set_cfg(input logic [PW-1:0] p, input logic [SW-1:0] l,
                           input logic [TW-1:0] t, input logic os);
        cfg_pattern = p; cfg_last = l; cfg_time = t; cfg_oneshot = os;
    endtask

    // Reset pulse raised between clock edges; outputs must clear at once.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_led",   32'(led),       32'(0));
        check_eq("rst_busy",  32'(busy),      32'(0));
        check_eq("rst_done",  32'(done),      32'(0));
        check_eq("rst_ready", 32'(cfg_ready), 32'(1));
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bit found;
        model_reset();
        #1 rst = 1'b1;
        #2 compare_all();
        @(negedge sys_clk);
        rst = 1'b0;
        tick();

        // 1: loop, 3 cycles/step, last=7 clamps to 5, config and start together
        set_cfg(24'h654321, 3'd7, 16'd3, 1'b0);
        cfg_valid = 1'b1; start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        check_eq("t1_first_led", 32'(led), 32'(1));
        for (int i = 0; i < 3; i++) tick();
        check_eq("t1_second_led", 32'(led), 32'(2));
        for (int i = 0; i < 15; i++) tick();
        check_eq("t1_wrap_led", 32'(led), 32'(1));
        check_eq("t1_wrap_step", 32'(step_idx), 32'(0));
        for (int i = 0; i < 10; i++) tick();
        stop = 1'b1; tick(); stop = 1'b0;

        // 2: one-shot, two 2-cycle steps, done on the cycle led returns to 0
        set_cfg(24'h0000A5, 3'd1, 16'd2, 1'b1);
        cfg_valid = 1'b1; start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        check_eq("t2_led0", 32'(led), 32'h5);
        tick(); check_eq("t2_led1", 32'(led), 32'h5);
        tick(); check_eq("t2_led2", 32'(led), 32'hA);
        tick(); check_eq("t2_led3", 32'(led), 32'hA);
        check_eq("t2_done_early", 32'(done), 32'(0));
        tick();
        check_eq("t2_led_end", 32'(led), 32'(0));
        check_eq("t2_done", 32'(done), 32'(1));
        check_eq("t2_busy", 32'(busy), 32'(0));
        tick(); check_eq("t2_done_once", 32'(done), 32'(0));

        // 3: loop time=4, new pattern sent mid step 3 applies at wrap
        set_cfg(24'h654321, 3'd5, 16'd4, 1'b0);
        cfg_valid = 1'b1; start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        for (int i = 0; i < 13; i++) tick();
        set_cfg(24'hFFFFFF, 3'd5, 16'd4, 1'b0);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check_eq("t3_ready_low", 32'(cfg_ready), 32'(0));
        check_eq("t3_old_led", 32'(led), 32'h4);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (step_idx == 3'd0) found = 1'b1;
        end
        check_eq("t3_wrap_seen", 32'(found), 32'(1));
        check_eq("t3_new_led", 32'(led), 32'hF);
        check_eq("t3_ready_back", 32'(cfg_ready), 32'(1));

        // 4: stop with start during step 2, cycle 1
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (step_idx == 3'd2) found = 1'b1;
        end
        check_eq("t4_step2_seen", 32'(found), 32'(1));
        tick();
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        check_eq("t4_led", 32'(led), 32'(0));
        check_eq("t4_busy", 32'(busy), 32'(0));
        check_eq("t4_step", 32'(step_idx), 32'(0));
        check_eq("t4_done", 32'(done), 32'(0));

        // 5: time=0, last=7 -> six 1-cycle steps then wrap
        set_cfg(24'h654321, 3'd7, 16'd0, 1'b0);
        cfg_valid = 1'b1; start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_eq("t5_step", 32'(step_idx), 32'(k % STEPS));
            tick();
        end

        // 6: async reset mid-run, then defaults (pattern 0, T=1, last=5)
        async_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t6_led", 32'(led), 32'(0));
        tick();
        check_eq("t6_step", 32'(step_idx), 32'(1));

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cfg_valid   = ($urandom_range(0, 5) == 0);
            cfg_pattern = PW'($urandom);
            cfg_last    = SW'($urandom_range(0, 7));
            cfg_time    = TW'($urandom_range(0, 3));
            cfg_oneshot = ($urandom_range(0, 2) == 0);
            start       = ($urandom_range(0, 3) == 0);
            stop        = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 400) == 0) async_reset();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
